// File: rtl/cache_ctrl_pkg.sv
// Shared types for the data-cache miss controller: queue opcodes, FSM states, packet field widths.
package cache_ctrl_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_FILL  = 2'd0,
    OP_WB    = 2'd1,
    OP_FLUSH = 2'd2
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LRU       = 3'd1,
    S_WB_REQ    = 3'd2,
    S_FILL_REQ  = 3'd3,
    S_FLUSH_REQ = 3'd4,
    S_WAIT      = 3'd5,
    S_REFILL    = 3'd6
  } state_t;

  // Packet width for a given geometry: {op, one-hot way, line address}.
  function automatic int ds_pkt_w(input int num_ways, input int addr_width);
    return OP_W + num_ways + addr_width;
  endfunction

endpackage

// File: rtl/cache_plru_tree.sv
// Per-set tree pseudo-LRU: combinational victim for rd_set, touch updates in one cycle.
// Latency: victim is combinational; a touch is visible the cycle after touch_en.
// Backpressure: none; touch_en is always accepted.
module cache_plru_tree #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 16,
  localparam int SET_W   = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  localparam int LVL     = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SET_W-1:0]    rd_set,
  output logic [NUM_WAYS-1:0] victim,
  input  logic                touch_en,
  input  logic [SET_W-1:0]    touch_set,
  input  logic [NUM_WAYS-1:0] touch_way
);

  // Heap-ordered nodes; level l decides way-index bit l (LSB at the root).
  logic [NUM_WAYS-2:0] bits_q [NUM_SETS];
  logic [NUM_WAYS-2:0] rd_tree;
  logic [NUM_WAYS-2:0] upd_tree;
  logic [LVL-1:0]      vidx;
  logic [LVL-1:0]      tidx;
  logic                b;
  int                  cur;
  int                  tcur;

  always_comb begin
    rd_tree = bits_q[rd_set];
    cur     = 0;
    vidx    = '0;
    b       = 1'b0;
    for (int l = 0; l < LVL; l++) begin
      b = 1'b0;
      for (int n = 0; n < NUM_WAYS-1; n++)
        if (n == cur) b = rd_tree[n];
      vidx[l] = b;
      cur     = 2*cur + (b ? 2 : 1);
    end
    victim       = '0;
    victim[vidx] = 1'b1;
  end

  always_comb begin
    tidx = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (touch_way[w]) tidx = LVL'(w);
    upd_tree = bits_q[touch_set];
    tcur     = 0;
    for (int l = 0; l < LVL; l++) begin
      for (int n = 0; n < NUM_WAYS-1; n++)
        if (n == tcur) upd_tree[n] = ~tidx[l];
      tcur = 2*tcur + (tidx[l] ? 2 : 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) bits_q[s] <= '0;
    end else if (touch_en) begin
      bits_q[touch_set] <= upd_tree;
    end
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Data-cache miss handler: victim pick, WB/FILL/FLUSH queue packets, refill beat forwarding.
// Latency: lookup to first packet 2 cycles; refill beats pass through one register stage.
// Backpressure: packets held stable until qrdy_i; rrdy_o = !dvld_o | drdy_i, full rate when streaming.
module cache_miss_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_WAYS    = 4,
  parameter int NUM_SETS    = 16,
  parameter int LINE_BEATS  = 4,
  parameter int OFFSET_BITS = 4,
  localparam int SET_W      = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  localparam int CNT_W      = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1,
  localparam int PKT_W      = ds_pkt_w(NUM_WAYS, ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  urdy_o,
  input  logic                  uvld_i,
  input  logic                  hit_i,
  input  logic                  we_i,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_WAYS-1:0]   hit_way_i,
  input  logic [NUM_WAYS-1:0]   valid_ways_i,
  input  logic [NUM_WAYS-1:0]   dirty_ways_i,
  input  logic                  qrdy_i,
  output logic                  qvld_o,
  output logic [PKT_W-1:0]      qdat_o,
  input  logic                  ack_i,
  output logic                  scan_o,
  input  logic                  rvld_i,
  output logic                  rrdy_o,
  input  logic [DATA_WIDTH-1:0] rdat_i,
  output logic                  dvld_o,
  input  logic                  drdy_i,
  output logic [DATA_WIDTH-1:0] ddat_o,
  output logic                  dlast_o
);

  typedef struct packed {
    op_t                   op;
    logic [NUM_WAYS-1:0]   way;
    logic [ADDR_WIDTH-1:0] addr;
  } ds_pkt_t;

  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(LINE_BEATS-1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

  state_t                state_q, state_n;
  logic                  urdy_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  flush_q;
  logic [NUM_WAYS-1:0]   hit_way_q, valid_q, dirty_q;
  logic [NUM_WAYS-1:0]   victim_q, victim_n;
  logic [NUM_WAYS-1:0]   plru_victim, inv_sel;
  logic [CNT_W-1:0]      cnt_q;
  logic                  dvld_q;
  logic [DATA_WIDTH-1:0] ddat_q;
  logic                  ubeat, rbeat, dbeat, last_in_buf;
  logic                  touch_en;
  logic [SET_W-1:0]      touch_set, set_in, set_q;
  logic [NUM_WAYS-1:0]   touch_way;
  ds_pkt_t               pkt;

  assign ubeat       = uvld_i & urdy_q;
  assign set_in      = addr_i[OFFSET_BITS +: SET_W];
  assign set_q       = addr_q[OFFSET_BITS +: SET_W];
  assign last_in_buf = dvld_q & (cnt_q == LAST_BEAT);
  assign dbeat       = dvld_q & drdy_i;
  // Once the final beat sits in the buffer, no further refill beats belong to this line.
  assign rrdy_o      = (state_q == S_REFILL) & (~dvld_q | drdy_i) & ~last_in_buf;
  assign rbeat       = rvld_i & rrdy_o;

  assign urdy_o  = urdy_q;
  assign scan_o  = (state_q != S_IDLE);
  assign dvld_o  = dvld_q;
  assign ddat_o  = ddat_q;
  assign dlast_o = last_in_buf;

  cache_plru_tree #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS)) u_plru (
    .clk       (clk),
    .reset     (reset),
    .rd_set    (set_q),
    .victim    (plru_victim),
    .touch_en  (touch_en),
    .touch_set (touch_set),
    .touch_way (touch_way)
  );

  // Hits touch in IDLE, fills touch on their ack; the two never coincide.
  always_comb begin
    touch_en  = 1'b0;
    touch_set = set_in;
    touch_way = hit_way_i;
    if (state_q == S_IDLE && ubeat && hit_i && !flush_i) begin
      touch_en = 1'b1;
    end else if (state_q == S_WAIT && ack_i && !flush_q) begin
      touch_en  = 1'b1;
      touch_set = set_q;
      touch_way = victim_q;
    end
  end

  always_comb begin
    inv_sel = '0;
    for (int w = NUM_WAYS-1; w >= 0; w--)
      if (!valid_q[w]) begin
        inv_sel    = '0;
        inv_sel[w] = 1'b1;
      end
  end

  always_comb begin
    state_n  = state_q;
    victim_n = victim_q;
    qvld_o   = 1'b0;
    pkt.op   = OP_FILL;
    case (state_q)
      S_IDLE: begin
        if (ubeat && (flush_i || (!hit_i && !we_i))) state_n = S_LRU;
      end
      S_LRU: begin
        if (flush_q) begin
          victim_n = hit_way_q;
          state_n  = (|hit_way_q) ? S_FLUSH_REQ : S_IDLE;
        end else begin
          victim_n = (|(~valid_q)) ? inv_sel : plru_victim;
          state_n  = (|(victim_n & valid_q & dirty_q)) ? S_WB_REQ : S_FILL_REQ;
        end
      end
      S_WB_REQ: begin
        qvld_o = 1'b1;
        pkt.op = OP_WB;
        if (qrdy_i) state_n = S_FILL_REQ;
      end
      S_FILL_REQ: begin
        qvld_o = 1'b1;
        pkt.op = OP_FILL;
        if (qrdy_i) state_n = S_WAIT;
      end
      S_FLUSH_REQ: begin
        qvld_o = 1'b1;
        pkt.op = OP_FLUSH;
        if (qrdy_i) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (ack_i) state_n = flush_q ? S_IDLE : S_REFILL;
      end
      S_REFILL: begin
        if (dbeat && last_in_buf) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    pkt.way  = victim_q;
    pkt.addr = addr_q & LINE_MASK;
    qdat_o   = qvld_o ? pkt : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      urdy_q    <= 1'b1;
      addr_q    <= '0;
      flush_q   <= 1'b0;
      hit_way_q <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
      victim_q  <= '0;
      cnt_q     <= '0;
      dvld_q    <= 1'b0;
      ddat_q    <= '0;
    end else begin
      state_q  <= state_n;
      urdy_q   <= (state_n == S_IDLE);
      victim_q <= victim_n;
      if (ubeat) begin
        addr_q    <= addr_i;
        flush_q   <= flush_i;
        hit_way_q <= hit_way_i;
        valid_q   <= valid_ways_i;
        dirty_q   <= dirty_ways_i;
      end
      if (rbeat) begin
        dvld_q <= 1'b1;
        ddat_q <= rdat_i;
      end else if (dbeat) begin
        dvld_q <= 1'b0;
      end
      if (dbeat) cnt_q <= last_in_buf ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule
